// File: rtl/stream_mux_arb.sv
// N-channel stream multiplexer with round-robin or steered selection,
// packet locking on last, and a registered output stage.
module stream_mux_arb #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  parameter  int MODE   = 0,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_last,
  input  logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SEL_W-1:0]        out_ch
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;

  logic             load, gnt_vld, xfer;
  logic [SEL_W-1:0] gnt_idx;
  int               idx;

  // At most one grant, and only when the output register can accept a beat.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    load    = !out_valid_q || out_ready;
    if (rst_n && load) begin
      if (state_q == LOCKED) begin
        gnt_vld = 1'b1;
        gnt_idx = lock_ch_q;
      end else if (MODE == 1) begin
        if (int'(sel) < NUM_CH) begin
          gnt_vld = 1'b1;
          gnt_idx = sel;
        end
      end else begin
        // Walk downward so the last hit is the nearest valid channel at/after rr_ptr.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
          idx = int'(rr_ptr_q) + k;
          if (idx >= NUM_CH) idx = idx - NUM_CH;
          if (in_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = SEL_W'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (gnt_vld) in_ready[gnt_idx] = 1'b1;
  end

  assign xfer = gnt_vld && in_valid[gnt_idx];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_ch_d   = lock_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_last_d  = in_last[gnt_idx];
      out_ch_d    = gnt_idx;
      if (in_last[gnt_idx]) begin
        state_d  = IDLE;
        rr_ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + SEL_W'(1);
      end else begin
        state_d   = LOCKED;
        lock_ch_d = gnt_idx;
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_ch_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Two DUTs: round-robin with 4 channels (dut0) and steered select with 5 channels (dut1),
// so an out-of-range sel is reachable. A queue scoreboard tracks every beat.
module tb_stream_mux_arb;
  localparam int W = 8, NMAX = 5;

  typedef struct { logic [7:0] data; logic last; int ch; } beat_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NMAX-1:0]   in_valid [2];
  logic [NMAX-1:0]   in_last  [2];
  logic [NMAX*W-1:0] in_data  [2];
  logic              out_ready[2];
  logic [1:0]        sel0;
  logic [2:0]        sel1;
  bit   [NMAX-1:0]   took     [2];
  int                pkt_left [2][NMAX];
  int                total = 0, bad = 0;

  wire [3:0] rdy0; wire [4:0] rdy1;
  wire ov0, ov1, ol0, ol1;
  wire [7:0] od0, od1;
  wire [1:0] oc0; wire [2:0] oc1;

  wire [NMAX-1:0] rdy [2];
  wire            ov  [2];
  wire            ol  [2];
  wire [7:0]      od  [2];
  wire [2:0]      och [2];
  assign rdy[0] = {1'b0, rdy0};  assign rdy[1] = rdy1;
  assign ov[0]  = ov0;           assign ov[1]  = ov1;
  assign ol[0]  = ol0;           assign ol[1]  = ol1;
  assign od[0]  = od0;           assign od[1]  = od1;
  assign och[0] = {1'b0, oc0};   assign och[1] = oc1;

  stream_mux_arb #(.WIDTH(8), .NUM_CH(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0][3:0]), .in_ready(rdy0),
    .in_data(in_data[0][31:0]), .in_last(in_last[0][3:0]), .sel(sel0),
    .out_valid(ov0), .out_ready(out_ready[0]), .out_data(od0), .out_last(ol0), .out_ch(oc0));

  stream_mux_arb #(.WIDTH(8), .NUM_CH(5), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy1),
    .in_data(in_data[1]), .in_last(in_last[1]), .sel(sel1),
    .out_valid(ov1), .out_ready(out_ready[1]), .out_data(od1), .out_last(ol1), .out_ch(oc1));

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_sb
    localparam int NCH = (d == 0) ? 4 : 5;
    beat_t sb[$];
    bit    locked = 1'b0;
    int    lock_ch = 0, ptr = 0;

    // Monitor: whatever sits in the output register must be the oldest unconsumed beat.
    always @(negedge clk) begin
      chk($sformatf("dut%0d out_valid", d), ov[d], sb.size() != 0);
      if (ov[d] === 1'b1 && sb.size() != 0) begin
        chk($sformatf("dut%0d out_data", d), od[d], sb[0].data);
        chk($sformatf("dut%0d out_last", d), ol[d], sb[0].last);
        chk($sformatf("dut%0d out_ch", d), och[d], sb[0].ch);
        if (out_ready[d]) void'(sb.pop_front());
      end
    end

    // Reference: decide the grant from the rules, check in_ready, record the transfer.
    always @(negedge clk) begin
      int g;
      logic [NMAX-1:0] e;
      beat_t b;
      #1;
      g = -1;
      e = '0;
      took[d] = '0;
      if (!rst_n) begin
        sb.delete();
        locked = 1'b0; ptr = 0; lock_ch = 0;
        chk($sformatf("dut%0d in_ready in reset", d), rdy[d], '0);
      end else begin
        if (sb.size() == 0) begin
          if (locked) g = lock_ch;
          else if (d == 0) begin
            for (int k = 0; k < NCH; k++)
              if (g < 0 && in_valid[d][(ptr + k) % NCH]) g = (ptr + k) % NCH;
          end else if (int'(sel1) < NCH) g = int'(sel1);
        end
        if (g >= 0) e[g] = 1'b1;
        chk($sformatf("dut%0d in_ready", d), rdy[d], e);
        if (g >= 0 && in_valid[d][g]) begin
          b.data = in_data[d][g*W +: W];
          b.last = in_last[d][g];
          b.ch   = g;
          sb.push_back(b);
          took[d][g] = 1'b1;
          if (b.last) begin locked = 1'b0; ptr = (g + 1) % NCH; end
          else begin locked = 1'b1; lock_ch = g; end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic put(int d, int c, logic [7:0] dat, logic lst, logic v);
    in_valid[d][c]       = v;
    in_data[d][c*W +: W] = dat;
    in_last[d][c]        = lst;
  endtask

  // Sources hold a beat until it is taken; packets are 1..4 beats long.
  task automatic rand_cycle();
    for (int d = 0; d < 2; d++) begin
      int nch = (d == 0) ? 4 : 5;
      out_ready[d] = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < nch; c++)
        if (took[d][c] || !in_valid[d][c]) begin
          if ($urandom_range(0, 3) != 0) begin
            if (pkt_left[d][c] == 0) pkt_left[d][c] = $urandom_range(1, 4);
            put(d, c, 8'($urandom), pkt_left[d][c] == 1, 1'b1);
            pkt_left[d][c]--;
          end else in_valid[d][c] = 1'b0;
        end
    end
    sel1 = 3'($urandom_range(0, 7));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = '0; in_last[d] = '0; in_data[d] = '0; out_ready[d] = 1'b1;
      for (int c = 0; c < NMAX; c++) pkt_left[d][c] = 0;
    end
    sel0 = '0; sel1 = 3'd7;
    step(); step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset out_valid", ov[d], 0); chk("reset out_data", od[d], 0);
      chk("reset out_last", ol[d], 0);  chk("reset out_ch", och[d], 0);
    end

    // Steered select sweep, one beat per cycle.
    step(); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) put(1, c, 8'(c + 1), 1'b1, 1'b1);
    sel1 = 3'd0;
    for (int k = 1; k <= 4; k++) begin
      step(); sel1 = (k < 4) ? 3'(k) : 3'd7;
      @(negedge clk);
      chk("t1 out_data", od[1], k); chk("t1 out_ch", och[1], k - 1);
    end

    // Out-of-range select grants nothing.
    step(); in_valid[1] = '0; put(1, 1, 8'h02, 1'b1, 1'b1); sel1 = 3'd5;
    @(negedge clk); chk("t5 in_ready sel5", rdy[1], 0);
    step(); sel1 = 3'd6;
    @(negedge clk); chk("t5 out_valid", ov[1], 0); chk("t5 in_ready sel6", rdy[1], 0);
    step(); sel1 = 3'd1;
    @(negedge clk); chk("t5 in_ready sel1", rdy[1], 5'b00010);
    step(); sel1 = 3'd7;
    @(negedge clk); chk("t5 out_data", od[1], 8'h02); chk("t5 out_ch", och[1], 1);
    step(); in_valid[1] = '0;

    // Round-robin rotation with all channels valid.
    for (int c = 0; c < 4; c++) put(0, c, 8'(8'h10 + c), 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(); @(negedge clk);
      chk("t2 out_ch", och[0], k % 4); chk("t2 out_data", od[0], 8'h10 + k % 4);
    end

    // Locked 3-beat packet on ch2, then rotation resumes at ch3.
    step(); in_valid[0] = '0; put(0, 2, 8'hA0, 1'b0, 1'b1);
    step(); put(0, 2, 8'hA1, 1'b0, 1'b1); put(0, 0, 8'h30, 1'b1, 1'b1); put(0, 3, 8'h33, 1'b1, 1'b1);
    @(negedge clk); chk("t3 beat0", od[0], 8'hA0); chk("t3 lock ready", rdy[0], 5'b00100);
    step(); put(0, 2, 8'hA2, 1'b1, 1'b1);
    @(negedge clk); chk("t3 beat1", od[0], 8'hA1); chk("t3 beat1 ch", och[0], 2);
    step(); in_valid[0][2] = 1'b0;
    @(negedge clk); chk("t3 beat2", od[0], 8'hA2); chk("t3 beat2 last", ol[0], 1);
    step(); in_valid[0][3] = 1'b0;
    @(negedge clk); chk("t3 next ch", och[0], 3); chk("t3 next data", od[0], 8'h33);
    step(); in_valid[0][0] = 1'b0;
    @(negedge clk); chk("t3 wrap ch", och[0], 0);

    // Backpressure hold and bubble-free release.
    put(0, 1, 8'h55, 1'b1, 1'b1);
    step(); put(0, 1, 8'h66, 1'b1, 1'b1); out_ready[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t4 stall data", od[0], 8'h55); chk("t4 stall valid", ov[0], 1);
      chk("t4 stall ready", rdy[0], 0);
      step();
    end
    out_ready[0] = 1'b1;
    @(negedge clk); chk("t4 release data", od[0], 8'h55); chk("t4 release ready", rdy[0], 5'b00010);
    step(); in_valid[0] = '0;
    @(negedge clk); chk("t4 no bubble", od[0], 8'h66); chk("t4 no bubble valid", ov[0], 1);

    // Reset in the middle of a 4-beat packet on ch1.
    step(); put(0, 1, 8'hB0, 1'b0, 1'b1);
    step(); put(0, 1, 8'hB1, 1'b0, 1'b1);
    step(); put(0, 1, 8'hB2, 1'b0, 1'b1); rst_n = 1'b0;
    @(negedge clk); chk("t6 ready in reset", rdy[0], 0);
    step(); rst_n = 1'b1; put(0, 0, 8'h70, 1'b1, 1'b1); put(0, 3, 8'h73, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6 out_valid", ov[0], 0); chk("t6 out_data", od[0], 0);
    chk("t6 out_ch", och[0], 0);   chk("t6 restart ready", rdy[0], 5'b00001);
    step(); @(negedge clk); chk("t6 restart data", od[0], 8'h70);
    step(); rst_n = 1'b0;
    for (int d = 0; d < 2; d++) in_valid[d] = '0;
    step(); rst_n = 1'b1;

    repeat (3000) begin
      rand_cycle();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
